// File: rtl/io_handshake_responder.sv
// ---------------------------------------------------------------------------
// io_handshake_responder
//
// Peripheral-side partner for the processor's four-phase byte I/O port.
// A processor request (hs_out) is answered with hs_in. On the capture edge
// the responder stores bus_out into the RX FIFO, loads bus_in from the TX
// FIFO head and pops the TX FIFO. Host logic fills TX and drains RX.
//
// Handshake semantics (host side, both FIFOs):
//   - A TX push happens on a rising g_clk edge where tx_valid && tx_ready.
//     tx_ready comes from the registered count, so a full FIFO refuses a
//     push even if the processor pops in the same cycle.
//   - An RX pop happens on a rising g_clk edge where rx_ready && rx_valid.
//     rx_ready while rx_valid is low is ignored.
//   - Host and processor sides may act in the same cycle; both take effect.
//
// Optional feature macro: IO_RESP_STALL_EN
//   defined   : the request is held in STALL until TX has data and RX has
//               room; ovf/unf never set.
//   undefined : every request is accepted at once; an empty TX yields
//               bus_in = 0 and sets unf, a full RX drops the byte and sets ovf.
//
// Ports:
//   g_clk, g_clr         clock, asynchronous active-high clear
//   hs_out, bus_out      processor request and output byte
//   hs_in, bus_in        acknowledge and registered byte to the processor
//   tx_data/valid/ready  host push side of the TX FIFO
//   rx_data/valid/ready  host pop side of the RX FIFO
//   tx_count, rx_count   FIFO occupancy, 0..depth
//   ovf, unf, flag_clr   sticky error flags and their synchronous clear
//   state_dbg            current FSM state (IDLE=0, STALL=1, ACK=2)
// ---------------------------------------------------------------------------
module io_handshake_responder #(
  parameter int d_width = 8,
  parameter int a_width = 2
) (
  input  logic               g_clk,
  input  logic               g_clr,
  input  logic               hs_out,
  input  logic [d_width-1:0] bus_out,
  output logic               hs_in,
  output logic [d_width-1:0] bus_in,
  input  logic [d_width-1:0] tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic [d_width-1:0] rx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic [a_width:0]   tx_count,
  output logic [a_width:0]   rx_count,
  output logic               ovf,
  output logic               unf,
  input  logic               flag_clr,
  output logic [1:0]         state_dbg
);

  localparam int depth = 1 << a_width;
  localparam logic [a_width:0] full_cnt = (a_width+1)'(depth);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t state_q, state_nx;
  logic   capture;
  logic   go;
  logic   ovf_set, unf_set;

  logic [d_width-1:0] tx_mem [depth];
  logic [d_width-1:0] rx_mem [depth];
  logic [a_width-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
  logic [a_width:0]   tx_cnt_q, rx_cnt_q;
  logic [d_width-1:0] bus_in_q;
  logic               hs_in_q, ovf_q, unf_q;

  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_push, tx_pop, rx_push, rx_pop;

  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == full_cnt);
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == full_cnt);

`ifdef IO_RESP_STALL_EN
  assign go      = !tx_empty && !rx_full;
  assign ovf_set = 1'b0;
  assign unf_set = 1'b0;
`else
  assign go      = 1'b1;
  assign ovf_set = capture && rx_full;
  assign unf_set = capture && tx_empty;
`endif

  assign tx_push = tx_valid && !tx_full;
  assign tx_pop  = capture && !tx_empty;
  assign rx_push = capture && !rx_full;
  assign rx_pop  = rx_ready && !rx_empty;

  // Next state. A capture only leaves IDLE or STALL, so a request held
  // high in ACK can never capture twice.
  always_comb begin
    state_nx = state_q;
    capture  = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs_out) begin
          if (go) begin
            capture  = 1'b1;
            state_nx = ACK;
          end else begin
            state_nx = STALL;
          end
        end
      end
      STALL: begin
        if (!hs_out) begin
          state_nx = IDLE;
        end else if (go) begin
          capture  = 1'b1;
          state_nx = ACK;
        end
      end
      ACK: begin
        if (!hs_out) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge g_clk or posedge g_clr) begin
    if (g_clr) begin
      state_q  <= IDLE;
      hs_in_q  <= 1'b0;
      bus_in_q <= '0;
      tx_wr    <= '0;
      tx_rd    <= '0;
      rx_wr    <= '0;
      rx_rd    <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q <= state_nx;
      // hs_in follows the state being entered, so it rises on the capture edge.
      hs_in_q <= (state_nx == ACK);
      if (capture) bus_in_q <= tx_empty ? '0 : tx_mem[tx_rd];
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
      tx_cnt_q <= tx_cnt_q + (a_width+1)'(tx_push) - (a_width+1)'(tx_pop);
      rx_cnt_q <= rx_cnt_q + (a_width+1)'(rx_push) - (a_width+1)'(rx_pop);
      if (flag_clr)     ovf_q <= 1'b0;
      else if (ovf_set) ovf_q <= 1'b1;
      if (flag_clr)     unf_q <= 1'b0;
      else if (unf_set) unf_q <= 1'b1;
    end
  end

  // Storage needs no reset; stale entries are never visible because
  // rx_data is gated by occupancy and bus_in only loads from a non-empty TX.
  always_ff @(posedge g_clk) begin
    if (tx_push) tx_mem[tx_wr] <= tx_data;
    if (rx_push) rx_mem[rx_wr] <= bus_out;
  end

  assign hs_in     = hs_in_q;
  assign bus_in    = bus_in_q;
  assign tx_ready  = !tx_full;
  assign rx_valid  = !rx_empty;
  assign rx_data   = rx_empty ? '0 : rx_mem[rx_rd];
  assign tx_count  = tx_cnt_q;
  assign rx_count  = rx_cnt_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_io_handshake_responder.sv
// ---------------------------------------------------------------------------
// tb_io_handshake_responder
//
// Directed bench for io_handshake_responder. Inputs change and outputs are
// sampled 1 ns after each rising edge. Expected values are hand-derived.
// ---------------------------------------------------------------------------
module tb_io_handshake_responder;

  logic       g_clk = 1'b0;
  logic       g_clr = 1'b0;
  logic       hs_out = 1'b0;
  logic [7:0] bus_out = '0;
  logic       hs_in;
  logic [7:0] bus_in;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [2:0] tx_count, rx_count;
  logic       ovf, unf;
  logic       flag_clr = 1'b0;
  logic [1:0] state_dbg;

  int checks = 0;
  int failures = 0;

  // ---- clock ----
  always #5 g_clk = ~g_clk;

  io_handshake_responder #(.d_width(8), .a_width(2)) dut (
    .g_clk(g_clk), .g_clr(g_clr),
    .hs_out(hs_out), .bus_out(bus_out), .hs_in(hs_in), .bus_in(bus_in),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_count(tx_count), .rx_count(rx_count),
    .ovf(ovf), .unf(unf), .flag_clr(flag_clr), .state_dbg(state_dbg)
  );

  // ---- checking ----
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---- driver tasks ----
  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
  endtask

  task automatic pop(input string tag, input logic [7:0] exp);
    chk(tag, rx_data, exp);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
  endtask

  task automatic handshake(input string tag, input logic [7:0] b, input logic [7:0] exp_bus_in);
    bus_out = b;
    hs_out  = 1'b1;
    chk({tag, "_hs_in_pre"}, hs_in, 0);
    step();
    chk({tag, "_hs_in_rise"}, hs_in, 1);
    chk({tag, "_bus_in"}, bus_in, exp_bus_in);
    hs_out = 1'b0;
    step();
    chk({tag, "_hs_in_fall"}, hs_in, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hs_in"}, hs_in, 0);
    chk({tag, "_bus_in"}, bus_in, 0);
    chk({tag, "_tx_ready"}, tx_ready, 1);
    chk({tag, "_rx_valid"}, rx_valid, 0);
    chk({tag, "_rx_data"}, rx_data, 0);
    chk({tag, "_tx_count"}, tx_count, 0);
    chk({tag, "_rx_count"}, rx_count, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_unf"}, unf, 0);
    chk({tag, "_state"}, state_dbg, 0);
  endtask

  // ---- directed sequence ----
  initial begin
    #1 g_clr = 1'b1;
    #2;
    chk_reset_vals("rst");
    @(posedge g_clk);
    @(posedge g_clk);
    #1 g_clr = 1'b0;

    // Basic transfer: two bytes each way.
    push(8'hA5);
    push(8'h3C);
    chk("tx_count_2", tx_count, 2);
    handshake("hs1", 8'h11, 8'hA5);
    handshake("hs2", 8'h22, 8'h3C);
    chk("rx_count_2", rx_count, 2);
    chk("tx_count_0", tx_count, 0);
    pop("rx_pop_11", 8'h11);
    pop("rx_pop_22", 8'h22);
    chk("rx_valid_empty", rx_valid, 0);

    // Request held in ACK for 10 cycles: only one capture.
    push(8'h77);
    bus_out = 8'h33;
    hs_out  = 1'b1;
    step();
    chk("hold_hs_in", hs_in, 1);
    for (int i = 0; i < 10; i++) begin
      bus_out = 8'h40 + 8'(i);
      step();
      chk("hold_hs_in_stay", hs_in, 1);
    end
    chk("hold_rx_count", rx_count, 1);
    chk("hold_tx_count", tx_count, 0);
    chk("hold_bus_in", bus_in, 8'h77);
    chk("hold_rx_data", rx_data, 8'h33);
    hs_out = 1'b0;
    step();
    chk("hold_release", hs_in, 0);

`ifndef IO_RESP_STALL_EN
    // Fill RX to 4, then overflow with an empty TX.
    push(8'h01);
    push(8'h02);
    push(8'h03);
    handshake("f1", 8'h44, 8'h01);
    handshake("f2", 8'h55, 8'h02);
    handshake("f3", 8'h66, 8'h03);
    chk("fill_rx_count", rx_count, 4);
    chk("fill_ovf", ovf, 0);
    chk("fill_unf", unf, 0);
    handshake("f5", 8'h99, 8'h00);
    chk("ovf_set", ovf, 1);
    chk("unf_set", unf, 1);
    chk("ovf_rx_count", rx_count, 4);
    chk("ovf_tx_count", tx_count, 0);
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    chk("ovf_clr", ovf, 0);
    chk("unf_clr", unf, 0);
    pop("drain_33", 8'h33);
    pop("drain_44", 8'h44);
    pop("drain_55", 8'h55);
    pop("drain_66", 8'h66);
    chk("drain_rx_valid", rx_valid, 0);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    chk("pop_empty_ignored", rx_count, 0);
`else
    pop("drain_33", 8'h33);
`endif

    // TX full: a further push is refused.
    push(8'hA1);
    push(8'hA2);
    push(8'hA3);
    push(8'hA4);
    chk("tx_full_ready", tx_ready, 0);
    push(8'hEE);
    chk("tx_full_count", tx_count, 4);

    // Reach ACK with TX=2 and RX=3, then clear mid-handshake.
    handshake("r1", 8'hB1, 8'hA1);
    handshake("r2", 8'hB2, 8'hA2);
    push(8'hA5);
    bus_out = 8'hB3;
    hs_out  = 1'b1;
    step();
    chk("r3_hs_in", hs_in, 1);
    chk("r3_bus_in", bus_in, 8'hA3);
    chk("r3_tx_count", tx_count, 2);
    chk("r3_rx_count", rx_count, 3);
    g_clr  = 1'b1;
    hs_out = 1'b0;
    #1;
    chk_reset_vals("midrst");
    step();
    g_clr = 1'b0;
    push(8'hBB);
    handshake("post", 8'hCC, 8'hBB);
    chk("post_rx_count", rx_count, 1);
    pop("post_rx", 8'hCC);

`ifdef IO_RESP_STALL_EN
    // Empty TX: the request waits in STALL until a byte arrives.
    hs_out  = 1'b1;
    bus_out = 8'hD0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_hs_in", hs_in, 0);
      chk("stall_state", state_dbg, 1);
    end
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    chk("stall_push_hs_in", hs_in, 0);
    step();
    chk("stall_ack_hs_in", hs_in, 1);
    chk("stall_bus_in", bus_in, 8'h5A);
    chk("stall_tx_count", tx_count, 0);
    chk("stall_rx_data", rx_data, 8'hD0);
    hs_out = 1'b0;
    step();
    chk("stall_release", hs_in, 0);
`endif

    // ---- final report ----
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_handshake_responder.md
# io_handshake_responder

Peripheral-side partner for the processor's byte I/O port. It answers the processor's `hs_out` request with `hs_in`, supplies the next byte on `bus_in`, and captures the byte on `bus_out`. Host logic sits on the far side and exchanges bytes with the processor through a transmit FIFO and a receive FIFO. It sits next to the processor top level, on the same clock.

## Interface
- `d_width`, 8: byte width of the bus and of both FIFOs.
- `a_width`, 2: FIFO address width. Depth is 2**`a_width` entries per FIFO.

Ports:
- `g_clk`, input, 1: clock. All state updates on the rising edge.
- `g_clr`, input, 1: global clear. Asynchronous, active-high.
- `hs_out`, input, 1: request from the processor.
- `bus_out`, input, `d_width`: processor output byte, sampled at capture.
- `hs_in`, output, 1: acknowledge to the processor.
- `bus_in`, output, `d_width`: byte supplied to the processor. Registered.
- `tx_data`, input, `d_width`: host byte to send to the processor.
- `tx_valid`, input, 1: host push request for the TX FIFO.
- `tx_ready`, output, 1: TX FIFO not full.
- `rx_data`, output, `d_width`: RX FIFO head.
- `rx_valid`, output, 1: RX FIFO not empty.
- `rx_ready`, input, 1: host pop request for the RX FIFO.
- `tx_count`, output, `a_width`+1: TX FIFO occupancy.
- `rx_count`, output, `a_width`+1: RX FIFO occupancy.
- `ovf`, output, 1: sticky flag, RX byte dropped.
- `unf`, output, 1: sticky flag, TX was empty at capture.
- `flag_clr`, input, 1: synchronous clear of `ovf` and `unf`.

## Operation
- FSM states: IDLE, STALL, ACK.
- **IDLE**
  - `hs_out`=1 and `go`=1: capture event, go to ACK.
  - `hs_out`=1 and `go`=0: go to STALL.
- **STALL:** stay until `go`=1 (capture event, go to ACK) or `hs_out`=0 (go to IDLE, no transfer).
- **ACK:** `hs_in`=1. When `hs_out`=0, go to IDLE.
- Capture event, all in one edge:
  - push `bus_out` into the RX FIFO;
  - load the `bus_in` register from the TX head;
  - pop the TX FIFO.
- `bus_in` holds its value until the next capture event.
- Exactly one capture per four-phase handshake. A request held high in ACK never produces a second capture.
- `hs_in` is a registered decode of state ACK.
- FIFOs:
  - circular buffers; read and write pointers wrap modulo depth;
  - counts are exact, 0..depth;
  - a host push and a transaction pop in the same cycle both take effect;
  - same for a host pop and a transaction push.
- A host push is accepted only when `tx_valid` and `tx_ready` are both high. `tx_ready` is computed from the registered count, so a full FIFO rejects a push even if a pop happens in the same cycle.
- A host pop while `rx_valid`=0 is ignored.
- `flag_clr` takes priority over a same-cycle flag set.

## Timing
- Reset values:
  - `hs_in`=0, `bus_in`=0;
  - `tx_ready`=1, `rx_valid`=0, `rx_data`=0;
  - both counts 0, `ovf`=0, `unf`=0;
  - state IDLE, all pointers 0.
- Latency:
  - `hs_out` rise with `go`=1 at edge N: capture at edge N, `hs_in`=1 and new `bus_in` visible after edge N.
  - `hs_out` fall seen at edge M: `hs_in`=0 after edge M.
- RX byte visible on `rx_data` one cycle after capture.
- Reset asserted mid-handshake: immediate return to reset values. If `hs_out` is still high after release, a new transaction starts from IDLE.

## Configuration
- `IO_RESP_STALL_EN` defined:
  - `go` = (TX not empty) and (RX not full); the responder withholds `hs_in` in STALL;
  - `ovf` and `unf` never set.
- `IO_RESP_STALL_EN` undefined:
  - `go`=1 always; STALL is unreachable;
  - TX empty at capture: `bus_in` loads 0, no pop, `unf` set;
  - RX full at capture: byte dropped, `ovf` set.

## Test plan
- Push 8'hA5, then 8'h3C. Run two processor handshakes with `bus_out` = 8'h11, then 8'h22.
  - `bus_in` = A5, then 3C.
  - `hs_in` rises one cycle after each `hs_out` rise.
  - RX pops give 11, then 22.
- Hold `hs_out`=1 for 10 cycles after `hs_in` rises.
  - Exactly one capture.
  - `rx_count`=1.
- With `IO_RESP_STALL_EN` defined and TX empty, raise `hs_out`.
  - `hs_in` stays 0.
  - Push 8'h5A at cycle 6: `hs_in`=1 and `bus_in`=5A the following cycle.
- Without the macro: fill RX to 4 entries, then run a 5th handshake with TX empty.
  - `ovf`=1, `unf`=1, `bus_in`=0, `rx_count`=4.
  - `flag_clr` clears both flags.
- Assert `g_clr` while in ACK with TX=2 and RX=3.
  - All outputs return to reset values immediately.
  - The next handshake after release captures normally.
